// File: rtl/i2s_tx.sv
// I2S transmitter: accepts left/right sample pairs through a valid/ready
// handshake, buffers one pair, and serialises frames MSB-first with BCK and WS.
// Optional feature macro: I2S_TX_UNDERRUN_REPEAT_EN (repeat last pair on underrun;
// when undefined, zeros are sent on underrun).
module i2s_tx #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned BCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                I2S_BCK,
    output logic                I2S_WS,
    output logic                I2S_DATA,
    output logic                underrun
);
    localparam int unsigned FRAME_W = 2 * SAMPLE_W;
    localparam int unsigned DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCK_DIV / 2);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WS_FIRST  = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] WS_LAST   = CNT_W'(FRAME_W - 2);

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_next;
    logic               bck_reg;
    logic               ws_reg;
    logic               data_reg;
    logic               data_next;
    logic               underrun_reg;
    logic [FRAME_W-1:0] hold;
    logic               hold_full;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] shift_next;
    logic [FRAME_W-1:0] empty_word;
    logic [FRAME_W-1:0] load_word;
    logic               boundary;
    logic               frame_load;
    logic               transfer;
    logic               ws_next;

    // Divider / slot counter next state; a boundary is the wrap of div_cnt (BCK falls)
    always_comb begin
        boundary   = (div_cnt == DIV_LAST);
        frame_load = boundary && (bit_cnt == SLOT_LAST);
        div_next   = boundary ? '0 : div_cnt + DIV_W'(1);
        bit_next   = bit_cnt;
        if (boundary) begin
            bit_next = (bit_cnt == SLOT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        end
        // WS leads each channel's MSB by one slot
        ws_next = (bit_next >= WS_FIRST) && (bit_next <= WS_LAST);
    end

    // A frame load frees the hold slot in the same cycle, so a new pair can enter
    assign in_ready = !hold_full || frame_load;
    assign transfer = in_valid && in_ready;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [FRAME_W-1:0] last_pair;

    // Remember the last pair that was actually loaded, for retransmission on underrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pair <= '0;
        end else if (frame_load && hold_full) begin
            last_pair <= hold;
        end
    end

    assign empty_word = last_pair;
`else
    assign empty_word = '0;
`endif

    assign load_word = hold_full ? hold : empty_word;

    // Shift register and serial data next state: load at slot 0, shift at other boundaries
    always_comb begin
        shift_next = shift_reg;
        data_next  = data_reg;
        if (frame_load) begin
            shift_next = load_word;
            data_next  = load_word[FRAME_W-1];
        end else if (boundary) begin
            shift_next = {shift_reg[FRAME_W-2:0], 1'b0};
            data_next  = shift_reg[FRAME_W-2];
        end
    end

    // Clock divider and registered BCK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bck_reg <= 1'b0;
        end else begin
            div_cnt <= div_next;
            bck_reg <= (div_next >= DIV_HALF);
        end
    end

    // Slot counter, WS, serial data and shift register; all move only at boundaries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= SLOT_LAST;
            ws_reg    <= 1'b0;
            data_reg  <= 1'b0;
            shift_reg <= '0;
        end else begin
            bit_cnt   <= bit_next;
            ws_reg    <= ws_next;
            data_reg  <= data_next;
            shift_reg <= shift_next;
        end
    end

    // One-entry input buffer; a simultaneous transfer keeps hold_full set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (transfer) begin
            hold      <= {in_left, in_right};
            hold_full <= 1'b1;
        end else if (frame_load) begin
            hold_full <= 1'b0;
        end
    end

    // Underrun pulse for the cycle following an empty frame load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= frame_load && !hold_full;
        end
    end

    assign I2S_BCK  = bck_reg;
    assign I2S_WS   = ws_reg;
    assign I2S_DATA = data_reg;
    assign underrun = underrun_reg;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, giving bits per channel sample (8..32).
REQ-002 SHALL have parameter BCK_DIV, default 4, giving clk cycles per BCK period (even, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; every register is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_left  input  SAMPLE_W  left sample, two's complement.
REQ-006 SHALL have port in_right  input  SAMPLE_W  right sample, two's complement.
REQ-007 SHALL have port in_valid  input  1  the sample pair is presented.
REQ-008 SHALL have port in_ready  output  1  the block accepts a pair this cycle.
REQ-009 SHALL have ports I2S_BCK, I2S_WS and I2S_DATA  output  1 each  the serial I2S bus.
REQ-010 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no sample buffered.

Function
REQ-011 Divider div_cnt SHALL count 0..BCK_DIV-1 and wrap; I2S_BCK SHALL be 0 for div_cnt < BCK_DIV/2 and 1 otherwise, and SHALL be registered.
REQ-012 A slot boundary SHALL occur on the clk edge where div_cnt wraps to 0, which is the falling edge of BCK.
REQ-013 Slot counter bit_cnt SHALL count 0..2*SAMPLE_W-1 and advance by one at each slot boundary, wrapping to 0.
REQ-014 I2S_DATA SHALL carry the left sample MSB-first in slots 0..SAMPLE_W-1 and the right sample MSB-first in slots SAMPLE_W..2*SAMPLE_W-1.
REQ-015 I2S_WS SHALL be 1 in slots SAMPLE_W-1..2*SAMPLE_W-2 and 0 otherwise, so that WS leads each channel's MSB by one BCK period.
REQ-016 I2S_DATA and I2S_WS SHALL change only at slot boundaries, on the same clk edge as the BCK falling edge.
REQ-017 The block SHALL hold a one-entry buffer (hold register plus hold_full) and a shift register.
REQ-018 in_ready SHALL equal !hold_full OR a frame load occurring this cycle.
REQ-019 A transfer SHALL occur when in_valid && in_ready, writing the pair to hold and setting hold_full.
REQ-020 At each boundary into slot 0 (frame load), if hold_full, hold SHALL move to the shift register and hold_full SHALL clear, unless a transfer occurs in the same cycle.
REQ-021 If a transfer and a frame load occur in the same cycle, the old hold SHALL be shifted out, the new pair SHALL enter hold, and hold_full SHALL stay 1.
REQ-022 On a frame load with hold empty, the block SHALL pulse underrun for one clk cycle and apply the REQ-029 underrun data.
REQ-023 Latency SHALL be as follows: a pair accepted into an empty hold SHALL appear on I2S_DATA starting at the next slot-0 boundary.
REQ-024 The block SHALL never drop a pair: in_ready SHALL be 0 while hold_full is 1 and no frame load occurs.

Reset
REQ-025 While reset_n is 0, the outputs SHALL be I2S_BCK=0, I2S_WS=0, I2S_DATA=0, in_ready=1 and underrun=0.
REQ-026 While reset_n is 0, the internal state SHALL be div_cnt=0, bit_cnt=2*SAMPLE_W-1, hold_full=0, shift register=0 and last-sample register=0.
REQ-027 After reset release, the first slot boundary SHALL be a frame load, occurring BCK_DIV clk cycles later.
REQ-028 Assertion of reset mid-frame SHALL immediately abort the frame and discard any buffered pair.

Configuration
REQ-029 Macro I2S_TX_UNDERRUN_REPEAT_EN SHALL select underrun data.
- Defined: on underrun the last successfully loaded pair SHALL be retransmitted.
- Undefined: on underrun zero SHALL be transmitted on both channels.
- In both cases the underrun pulse SHALL be generated.

Verification
REQ-030 SHALL cover: default parameters, reset release, in_valid held 0 -> BCK period 4 clk, frame 128 clk, WS rises at slot 15, underrun pulses every 128 clk, DATA stays 0.
REQ-031 SHALL cover: L=16'hA5C3, R=16'h0F01 accepted before the first load -> DATA slots 0..15 = A5C3 MSB-first and slots 16..31 = 0F01, each sampled on BCK rise.
REQ-032 SHALL cover: back-to-back pairs with in_valid held 1 -> in_ready low except during the load cycle, one pair per 128 clk, no underrun, no pair lost or duplicated.
REQ-033 SHALL cover: transfer in the exact frame-load cycle -> old pair shifted out, new pair in the next frame.
REQ-034 SHALL cover: underrun after L=16'h8001 -> next frame repeats 8001 with the macro defined and outputs 0000 with it undefined, underrun=1 for 1 cycle.
REQ-035 SHALL cover: reset_n pulsed low at slot 20 -> all outputs reach reset values on the same clk edge, hold discarded, timing restarts per REQ-027.
